perif_timer: RTL

- Programmable down-counting timer peripheral on the device side of the CPU I/O port interface.
- The CPU configures it through two output-port registers and reads its status and count through two input ports.
- On each expiry it raises a level interrupt request to the interrupt manager and holds it until the CPU signals end-of-interrupt.
- It fills the timer slot of the datapath: one intPortN line, one finInterrup acknowledge, two output ports, two input ports.

---
 rtl/perif_timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/perif_timer.sv
`default_nettype none
// ============================================================================
//  Module   : perif_timer
//  Purpose  : Programmable down-counting timer peripheral with prescaler,
//             one-shot/auto-reload modes and a level interrupt request.
//  Revision : 1.0  initial release
// ============================================================================
module perif_timer #(
    parameter int W  = 8,
    parameter int PW = 8   // must be >= 7 so the largest prescale (2^7) fits
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   ctrl_in,
    input  logic         we_ctrl,
    input  logic [W-1:0] period_in,
    input  logic         we_period,
    input  logic         ack,
    output logic         irq,
    output logic [7:0]   status,
    output logic [W-1:0] count
);

    localparam logic [W-1:0]  c_cnt_one   = W'(1);
    localparam logic [PW-1:0] c_presc_one = PW'(1);

    logic          r_auto;
    logic          r_irq_en;
    logic [2:0]    r_presc;
    logic [W-1:0]  r_period;
    logic [W-1:0]  r_cnt;
    logic [PW-1:0] r_prescaler;
    logic          r_pending;
    logic          r_overrun;
    logic          r_running;

    logic [PW-1:0] w_presc_max;
    logic          w_launch;
    logic          w_stop;
    logic          w_tick;
    logic          w_expire;
    logic          w_event_irq;
    logic [W-1:0]  w_period_next;
    logic          w_unused_ctrl;

    assign w_unused_ctrl = &{1'b0, ctrl_in[7:6]};

    // Terminal prescaler value 2^n - 1, formed as a low-bit mask.
    assign w_presc_max   = ~({PW{1'b1}} << r_presc);
    assign w_launch      = we_ctrl && ctrl_in[0] && !r_running;
    assign w_stop        = we_ctrl && !ctrl_in[0];
    // A stop write freezes the counter at this edge, so it also swallows a tick.
    assign w_tick        = r_running && !w_stop && (r_prescaler == w_presc_max);
    assign w_expire      = w_tick && (r_cnt == '0);
    assign w_event_irq   = w_expire && r_irq_en;
    assign w_period_next = we_period ? period_in : r_period;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_auto      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_presc     <= 3'd0;
            r_period    <= '0;
            r_cnt       <= '0;
            r_prescaler <= '0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            if (we_period) begin
                r_period <= period_in;
            end

            if (we_ctrl) begin
                r_auto   <= ctrl_in[1];
                r_irq_en <= ctrl_in[2];
                r_presc  <= ctrl_in[5:3];
            end

            if (w_launch) begin
                r_running <= 1'b1;
            end else if (w_stop) begin
                r_running <= 1'b0;
            end else if (w_expire && !r_auto) begin
                r_running <= 1'b0;
            end

            if (w_launch) begin
                r_cnt <= w_period_next;
            end else if (we_period && !r_running) begin
                r_cnt <= period_in;
            end else if (w_tick) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_cnt_one;
                end else if (r_auto) begin
                    r_cnt <= w_period_next;
                end
            end

            if (w_launch) begin
                r_prescaler <= '0;
            end else if (r_running && !w_stop) begin
                r_prescaler <= w_tick ? '0 : r_prescaler + c_presc_one;
            end

            // An expiry coinciding with ack keeps the request pending.
            if (w_event_irq) begin
                r_pending <= 1'b1;
            end else if (ack) begin
                r_pending <= 1'b0;
            end

            if (w_event_irq && r_pending) begin
                r_overrun <= 1'b1;
            end else if (we_ctrl) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign irq    = r_pending;
    assign status = {r_pending, r_overrun, r_running, r_auto, r_irq_en, r_presc};
    assign count  = r_cnt;

endmodule
`default_nettype wire
